// File: rtl/ecpri_tx_sched.sv
// Response scheduler: captures write/read response requests from ecpri_rx, arbitrates
// round-robin and serialises each granted response as an eCPRI byte frame.
module ecpri_tx_sched (
  input  logic       clk,
  input  logic       reset,
  input  logic       send_write_resp,
  input  logic       send_read_resp,
  input  logic [7:0] info_to_tx,
  input  logic [7:0] tx_payload_len,
  output logic       mem_rd_en,
  output logic [7:0] mem_rd_addr,
  input  logic [7:0] mem_rd_data,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       tx_sop,
  output logic       tx_eop,
  output logic       busy,
  output logic [7:0] drop_cnt
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StHdr   = 2'd1;
  localparam logic [1:0] StFetch = 2'd2;
  localparam logic [1:0] StSend  = 2'd3;

  logic [1:0] state_q, state_d;

  // Pending request slots
  logic       wr_vld_q;
  logic [7:0] wr_info_q;
  logic       rd_vld_q;
  logic [7:0] rd_info_q;
  logic [7:0] rd_len_q;
  logic       last_rd_q;

  // Working registers for the frame in progress
  logic       cur_rd_q;
  logic [7:0] cur_info_q;
  logic [7:0] cur_len_q;
  logic [2:0] byte_cnt_q;
  logic [7:0] addr_q;
  logic [7:0] hold_q;
  logic       fresh_q;
  logic [7:0] drop_cnt_q;

  logic       grant_wr, grant_rd, grant_any;
  logic       accept;
  logic       drop_wr, drop_rd;
  logic [8:0] drop_sum;
  logic [8:0] plen;
  logic       last_hdr, hdr_ends_frame, last_pay;

  always_comb begin
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (state_q == StIdle) begin
      if (wr_vld_q && rd_vld_q) begin
        grant_wr = last_rd_q;
        grant_rd = !last_rd_q;
      end else begin
        grant_wr = wr_vld_q;
        grant_rd = rd_vld_q;
      end
    end
  end

  assign grant_any      = grant_wr || grant_rd;
  assign accept         = tx_valid && tx_ready;
  assign drop_wr        = send_write_resp && wr_vld_q && !grant_wr;
  assign drop_rd        = send_read_resp && rd_vld_q && !grant_rd;
  assign drop_sum       = {1'b0, drop_cnt_q} + {8'd0, drop_wr} + {8'd0, drop_rd};
  assign plen           = cur_rd_q ? ({1'b0, cur_len_q} + 9'd2) : 9'd2;
  assign last_hdr       = (byte_cnt_q == 3'd5);
  assign hdr_ends_frame = !cur_rd_q || (cur_len_q == 8'd0);
  assign last_pay       = (addr_q == (cur_len_q - 8'd1));

  // Frame outputs are decoded from registered state so reset clears them at once.
  always_comb begin
    tx_data = 8'h00;
    case (state_q)
      StHdr: begin
        case (byte_cnt_q)
          3'd0:    tx_data = 8'h10;
          3'd1:    tx_data = 8'h04;
          3'd2:    tx_data = {7'd0, plen[8]};
          3'd3:    tx_data = plen[7:0];
          3'd4:    tx_data = cur_info_q;
          default: tx_data = cur_rd_q ? 8'h02 : 8'h01;
        endcase
      end
      // Memory data lands in the first SEND cycle; it is held from then on.
      StSend:  tx_data = fresh_q ? mem_rd_data : hold_q;
      default: tx_data = 8'h00;
    endcase
  end

  assign tx_valid    = (state_q == StHdr) || (state_q == StSend);
  assign tx_sop      = (state_q == StHdr) && (byte_cnt_q == 3'd0);
  assign tx_eop      = ((state_q == StHdr) && last_hdr && hdr_ends_frame) ||
                       ((state_q == StSend) && last_pay);
  assign busy        = (state_q != StIdle);
  assign mem_rd_en   = (state_q == StFetch);
  assign mem_rd_addr = addr_q;
  assign drop_cnt    = drop_cnt_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (grant_any) state_d = StHdr;
      StHdr:   if (accept && last_hdr) state_d = hdr_ends_frame ? StIdle : StFetch;
      StFetch: state_d = StSend;
      default: if (accept) state_d = last_pay ? StIdle : StFetch;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      wr_vld_q   <= 1'b0;
      wr_info_q  <= 8'h00;
      rd_vld_q   <= 1'b0;
      rd_info_q  <= 8'h00;
      rd_len_q   <= 8'h00;
      last_rd_q  <= 1'b1;
      cur_rd_q   <= 1'b0;
      cur_info_q <= 8'h00;
      cur_len_q  <= 8'h00;
      byte_cnt_q <= 3'd0;
      addr_q     <= 8'h00;
      hold_q     <= 8'h00;
      fresh_q    <= 1'b0;
      drop_cnt_q <= 8'h00;
    end else begin
      state_q <= state_d;

      // A new request loaded on the granting edge wins over the clear.
      if (send_write_resp && (!wr_vld_q || grant_wr)) begin
        wr_vld_q  <= 1'b1;
        wr_info_q <= info_to_tx;
      end else if (grant_wr) begin
        wr_vld_q <= 1'b0;
      end

      if (send_read_resp && (!rd_vld_q || grant_rd)) begin
        rd_vld_q  <= 1'b1;
        rd_info_q <= info_to_tx;
        rd_len_q  <= tx_payload_len;
      end else if (grant_rd) begin
        rd_vld_q <= 1'b0;
      end

      drop_cnt_q <= drop_sum[8] ? 8'hFF : drop_sum[7:0];

      if (grant_any) begin
        cur_rd_q   <= grant_rd;
        cur_info_q <= grant_rd ? rd_info_q : wr_info_q;
        cur_len_q  <= grant_rd ? rd_len_q : 8'h00;
        last_rd_q  <= grant_rd;
        byte_cnt_q <= 3'd0;
      end

      if ((state_q == StHdr) && accept) begin
        byte_cnt_q <= byte_cnt_q + 3'd1;
        if (last_hdr) addr_q <= 8'h00;
      end

      if (state_q == StFetch) fresh_q <= 1'b1;

      if (state_q == StSend) begin
        if (fresh_q) begin
          hold_q  <= mem_rd_data;
          fresh_q <= 1'b0;
        end
        if (accept && !last_pay) addr_q <= addr_q + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ecpri_tx_sched.sv
// Directed bench for ecpri_tx_sched: table of single-request frames plus hand-written
// sequences for arbitration, drops, back-pressure and mid-frame reset.
module tb_ecpri_tx_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       send_write_resp = 1'b0;
  logic       send_read_resp = 1'b0;
  logic [7:0] info_to_tx = 8'h00;
  logic [7:0] tx_payload_len = 8'h00;
  logic       mem_rd_en;
  logic [7:0] mem_rd_addr;
  logic [7:0] mem_rd_data = 8'h00;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic       tx_sop;
  logic       tx_eop;
  logic       busy;
  logic [7:0] drop_cnt;

  always #5 clk = ~clk;

  ecpri_tx_sched dut (
    .clk             (clk),
    .reset           (reset),
    .send_write_resp (send_write_resp),
    .send_read_resp  (send_read_resp),
    .info_to_tx      (info_to_tx),
    .tx_payload_len  (tx_payload_len),
    .mem_rd_en       (mem_rd_en),
    .mem_rd_addr     (mem_rd_addr),
    .mem_rd_data     (mem_rd_data),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .tx_sop          (tx_sop),
    .tx_eop          (tx_eop),
    .busy            (busy),
    .drop_cnt        (drop_cnt)
  );

  typedef struct {
    logic [7:0] d;
    logic       sop;
    logic       eop;
    int         c;
  } beat_t;

  typedef struct {
    bit         is_rd;
    logic [7:0] info;
    logic [7:0] len;
    logic [7:0] b2;
    logic [7:0] b3;
    logic [7:0] b5;
  } vec_t;

  beat_t      rx_q[$];
  int         rd_q[$];
  logic [7:0] mem[256];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  logic       stall_q = 1'b0;
  beat_t      stall_b;
  bit         toggle_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Synchronous response memory: data one cycle after the strobe.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (toggle_en) tx_ready = ~tx_ready;
  end

  always @(negedge clk) begin
    if (stall_q) begin
      check("stall_valid", int'(tx_valid), 1);
      check("stall_hold", int'({tx_data, tx_sop, tx_eop}),
            int'({stall_b.d, stall_b.sop, stall_b.eop}));
    end
    stall_q   <= tx_valid && !tx_ready;
    stall_b.d   <= tx_data;
    stall_b.sop <= tx_sop;
    stall_b.eop <= tx_eop;
    if (tx_valid && tx_ready) rx_q.push_back('{d: tx_data, sop: tx_sop, eop: tx_eop, c: cyc});
    if (mem_rd_en) rd_q.push_back(int'(mem_rd_addr));
  end

  // Caller is at posedge+1; drives the pulse for exactly one cycle.
  task automatic pulse(input bit wr, input bit rd, input logic [7:0] info,
                       input logic [7:0] len, output int t);
    send_write_resp = wr;
    send_read_resp  = rd;
    info_to_tx      = info;
    tx_payload_len  = len;
    t = cyc;
    @(posedge clk);
    #1;
    send_write_resp = 1'b0;
    send_read_resp  = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    repeat (4) @(posedge clk);
    #1;
    check("byte_count", rx_q.size(), n);
  endtask

  task automatic check_frame(input string nm, input int base, input logic [7:0] info,
                             input logic [7:0] len, input logic [7:0] b2, input logic [7:0] b3,
                             input logic [7:0] b5, input bit chk_time);
    logic [7:0] exp_d[$];
    int n;
    n = (b5 == 8'h02) ? 6 + int'(len) : 6;
    exp_d.push_back(8'h10);
    exp_d.push_back(8'h04);
    exp_d.push_back(b2);
    exp_d.push_back(b3);
    exp_d.push_back(info);
    exp_d.push_back(b5);
    for (int i = 0; i < n - 6; i++) exp_d.push_back(mem[i]);
    if (rx_q.size() < base + n) begin
      check({nm, "_short"}, rx_q.size(), base + n);
      return;
    end
    for (int i = 0; i < n; i++) begin
      check({nm, "_byte"}, int'(rx_q[base + i].d), int'(exp_d[i]));
      check({nm, "_flags"}, int'({rx_q[base + i].sop, rx_q[base + i].eop}),
            int'({i == 0, i == n - 1}));
    end
    if (chk_time)
      check({nm, "_spacing"}, rx_q[base + n - 1].c - rx_q[base].c,
            (n == 6) ? 5 : 5 + 2 * (n - 6));
  endtask

  vec_t vecs[5];

  initial begin
    int t0, t1, npay, k, n_before;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
    mem[0] = 8'hAA;
    mem[1] = 8'hBB;
    mem[2] = 8'hCC;

    vecs[0] = '{is_rd: 1'b0, info: 8'h5A, len: 8'h07, b2: 8'h00, b3: 8'h02, b5: 8'h01};
    vecs[1] = '{is_rd: 1'b1, info: 8'h33, len: 8'h03, b2: 8'h00, b3: 8'h05, b5: 8'h02};
    vecs[2] = '{is_rd: 1'b1, info: 8'h77, len: 8'h00, b2: 8'h00, b3: 8'h02, b5: 8'h02};
    vecs[3] = '{is_rd: 1'b1, info: 8'h81, len: 8'hFF, b2: 8'h01, b3: 8'h01, b5: 8'h02};
    vecs[4] = '{is_rd: 1'b1, info: 8'hC4, len: 8'hFE, b2: 8'h01, b3: 8'h00, b5: 8'h02};

    #12;
    check("rst_valid", int'(tx_valid), 0);
    check("rst_sop", int'(tx_sop), 0);
    check("rst_eop", int'(tx_eop), 0);
    check("rst_rd_en", int'(mem_rd_en), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_data", int'(tx_data), 0);
    check("rst_addr", int'(mem_rd_addr), 0);
    check("rst_drop", int'(drop_cnt), 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Simultaneous pairs: write wins the first tie, then alternation gives write again.
    rx_q.delete();
    rd_q.delete();
    pulse(1'b1, 1'b1, 8'h11, 8'h02, t0);
    wait_bytes(14, 200);
    check_frame("pairA_wr", 0, 8'h11, 8'h00, 8'h00, 8'h02, 8'h01, 1'b1);
    check_frame("pairA_rd", 6, 8'h11, 8'h02, 8'h00, 8'h04, 8'h02, 1'b1);
    if (rx_q.size() >= 14) begin
      check("pairA_lat", rx_q[0].c - t0, 2);
      check("pairA_gap", rx_q[6].c - rx_q[5].c, 2);
    end
    check("pairA_reads", rd_q.size(), 2);
    rx_q.delete();
    rd_q.delete();
    pulse(1'b1, 1'b1, 8'h12, 8'h01, t0);
    wait_bytes(13, 200);
    check_frame("pairB_wr", 0, 8'h12, 8'h00, 8'h00, 8'h02, 8'h01, 1'b1);
    check_frame("pairB_rd", 6, 8'h12, 8'h01, 8'h00, 8'h03, 8'h02, 1'b1);

    for (int v = 0; v < 5; v++) begin
      rx_q.delete();
      rd_q.delete();
      pulse(!vecs[v].is_rd, vecs[v].is_rd, vecs[v].info, vecs[v].len, t0);
      npay = vecs[v].is_rd ? int'(vecs[v].len) : 0;
      wait_bytes(6 + npay, 1000);
      check_frame($sformatf("vec%0d", v), 0, vecs[v].info, vecs[v].len, vecs[v].b2,
                  vecs[v].b3, vecs[v].b5, 1'b1);
      if (rx_q.size() > 0) check($sformatf("vec%0d_lat", v), rx_q[0].c - t0, 2);
      check($sformatf("vec%0d_reads", v), rd_q.size(), npay);
      if (npay > 0 && rd_q.size() > 0) begin
        check($sformatf("vec%0d_addr0", v), rd_q[0], 0);
        check($sformatf("vec%0d_addrN", v), rd_q[rd_q.size() - 1], npay - 1);
      end
      check($sformatf("vec%0d_busy", v), int'(busy), 0);
      check($sformatf("vec%0d_drop", v), int'(drop_cnt), 0);
    end

    // Second write on the granting edge is loaded, not dropped.
    rx_q.delete();
    pulse(1'b1, 1'b0, 8'hA1, 8'h00, t0);
    pulse(1'b1, 1'b0, 8'hA2, 8'h00, t1);
    wait_bytes(12, 200);
    check_frame("setwin_1", 0, 8'hA1, 8'h00, 8'h00, 8'h02, 8'h01, 1'b1);
    check_frame("setwin_2", 6, 8'hA2, 8'h00, 8'h00, 8'h02, 8'h01, 1'b1);
    check("setwin_drop", int'(drop_cnt), 0);

    // Write pending behind a busy frame: the repeat is dropped; ready toggles throughout.
    rx_q.delete();
    rd_q.delete();
    toggle_en = 1'b1;
    pulse(1'b0, 1'b1, 8'h3C, 8'h02, t0);
    @(posedge clk);
    #1;
    check("drop_busy", int'(busy), 1);
    pulse(1'b1, 1'b0, 8'h66, 8'h00, t1);
    pulse(1'b1, 1'b0, 8'h67, 8'h00, t1);
    wait_bytes(14, 400);
    toggle_en = 1'b0;
    @(posedge clk);
    #2;
    tx_ready = 1'b1;
    check_frame("bp_rd", 0, 8'h3C, 8'h02, 8'h00, 8'h04, 8'h02, 1'b0);
    check_frame("bp_wr", 8, 8'h66, 8'h00, 8'h00, 8'h02, 8'h01, 1'b0);
    check("drop_cnt", int'(drop_cnt), 1);

    // Reset in the middle of a read payload.
    @(posedge clk);
    #1;
    rx_q.delete();
    pulse(1'b0, 1'b1, 8'hE5, 8'h08, t0);
    k = 0;
    while (rx_q.size() < 8 && k < 200) begin
      @(posedge clk);
      k++;
    end
    check("mid_progress", int'(rx_q.size() >= 8), 1);
    #3;
    reset = 1'b0;
    #1;
    check("mid_valid", int'(tx_valid), 0);
    check("mid_busy", int'(busy), 0);
    check("mid_eop", int'(tx_eop), 0);
    check("mid_rd_en", int'(mem_rd_en), 0);
    check("mid_drop", int'(drop_cnt), 0);
    n_before = rx_q.size();
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    check("mid_no_bytes", rx_q.size(), n_before);
    @(posedge clk);
    #1;
    rx_q.delete();
    pulse(1'b1, 1'b0, 8'h9C, 8'h00, t0);
    wait_bytes(6, 100);
    check_frame("post_rst", 0, 8'h9C, 8'h00, 8'h00, 8'h02, 8'h01, 1'b1);
    if (rx_q.size() > 0) check("post_rst_lat", rx_q[0].c - t0, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ecpri_tx_sched.md
# ecpri_tx_sched

Response scheduler between `ecpri_rx` and the eCPRI transmit path. It captures the write- and read-response requests that `ecpri_rx` raises for remote memory access messages and arbitrates between them round-robin. It serialises each granted response as an eCPRI byte frame on a valid/ready stream. For read responses it fetches the payload bytes from the shared response memory that `ecpri_rx` fills via `data_to_mem`.

## Interface
Parameters:
- none; all widths are fixed at 8 bits to match `ecpri_rx`.

Ports:
- `clk`  in  1  single clock; every register is rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `send_write_resp`  in  1  one-cycle request pulse from `ecpri_rx`.
- `send_read_resp`  in  1  one-cycle request pulse from `ecpri_rx`.
- `info_to_tx`  in  8  remote memory access ID; sampled with either request.
- `tx_payload_len`  in  8  read byte count N; sampled with `send_read_resp`, ignored for writes.
- `mem_rd_en`  out  1  memory read strobe; data returns 1 cycle later.
- `mem_rd_addr`  out  8  memory byte address.
- `mem_rd_data`  in  8  memory read data.
- `tx_data`  out  8  frame byte.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  sink accepts the byte.
- `tx_sop`  out  1  first byte of a frame; qualified by `tx_valid`.
- `tx_eop`  out  1  last byte of a frame; qualified by `tx_valid`.
- `busy`  out  1  a frame is in progress.
- `drop_cnt`  out  8  count of dropped requests; saturates at 255.

## Operation
**Pending slots**
- There is one slot per type. The write slot holds `{valid, info}`; the read slot holds `{valid, info, len}`.
- A request pulse sets its slot.
- If the slot is already valid and not being granted that cycle, the new request is dropped, the slot contents are kept, and `drop_cnt` increments.
- If the grant and a new same-type request fall on the same edge, the new request is loaded: set wins over clear.
- Simultaneous write and read pulses fill both slots.

**Arbitration**
- Arbitration happens only in IDLE.
- If exactly one slot is valid, it is granted.
- If both are valid, the type not granted last time wins. After reset, `last_grant` = read, so write wins the first tie.
- The grant latches the slot contents into working registers and clears the slot.

**FSM states:** IDLE, HDR, FETCH, SEND.
- IDLE -> HDR on grant.
- HDR emits 6 bytes, indexed by a byte counter:
  - B0: 0x10
  - B1: 0x04
  - B2: P[8]
  - B3: P[7:0]
  - B4: info
  - B5: 0x02 for a read response, 0x01 for a write response
- P is 9 bits: P = 2 + N for reads, P = 2 for writes. N = 255 gives B2 = 0x01, B3 = 0x01.
- After B5 is accepted:
  - write, or read with N = 0: B5 carries `tx_eop`, then the FSM returns to IDLE.
  - read with N > 0: go to FETCH with address counter = 0.
- FETCH: for one cycle, `mem_rd_en` = 1 and `mem_rd_addr` = counter. Next state is SEND.
- SEND: `tx_data` = `mem_rd_data` captured on the FETCH->SEND edge; `tx_valid` = 1.
  - On acceptance, if counter = N-1, assert `tx_eop` on this byte and go to IDLE.
  - Otherwise increment the counter and go to FETCH.
- `busy` = 1 in every state except IDLE.

## Timing
**Reset values:** `tx_valid`, `tx_sop`, `tx_eop`, `mem_rd_en`, `busy` = 0. `tx_data`, `mem_rd_addr`, `drop_cnt` = 0. Both slots are invalid and the FSM is in IDLE. Asserting reset mid-frame aborts immediately: `tx_valid` drops asynchronously and there is no `tx_eop`.

**Latency:** a request pulse in cycle t is stored at the end of t. The grant happens in cycle t+1. B0 is presented with `tx_valid` = 1 and `tx_sop` = 1 in cycle t+2.

**Handshake:**
- A byte transfers when `tx_valid` && `tx_ready`.
- While `tx_valid` && !`tx_ready`, `tx_data`, `tx_sop` and `tx_eop` stay stable.
- With continuous ready, header bytes go out 1 per cycle.
- Payload bytes go out 1 per 2 cycles, because FETCH has `tx_valid` = 0.

**Frame gap:** after an EOP is accepted, the FSM is IDLE for 1 cycle. The next frame's B0 appears at the earliest 2 cycles after EOP acceptance.

**Address rule:** `mem_rd_addr` is 8 bits and never wraps within a frame, since the maximum address is N-1 = 254.

## Test plan
- Single write request, info = 0x5A, `tx_ready` = 1: bytes 10 04 00 02 5A 01; SOP on byte 0, EOP on byte 5; B0 appears 2 cycles after the pulse.
- Single read request, info = 0x33, N = 3, memory[0..2] = AA BB CC: bytes 10 04 00 05 33 02 AA BB CC; 3 `mem_rd_en` pulses at addresses 0, 1, 2; EOP on CC.
- Write and read pulses in the same cycle right after reset: write frame first, then read frame. Then a second simultaneous pair: this tie goes to the write because the read was granted last (alternation), so the order is write, read again.
- Read with N = 255: B2 = 0x01, B3 = 0x01, 255 payload bytes, last address 0xFE.
- A second write pulse while the first is pending but not yet granted: `drop_cnt` = 1, only one write frame. `tx_ready` toggled 0/1 mid-frame: data held stable, no byte lost or duplicated.
- `reset` asserted during the payload of a read frame: `tx_valid` = 0 at once, `busy` = 0. After release, a new write request produces a complete frame.
